// File: rtl/cache_pkg.sv
// ---------------------------------------------------------------------------
// cache_pkg
// Shared constants, types and address helpers for the direct-mapped cache
// store. The address is split as:
//   [1:0]                offset (ignored, one word per line)
//   [INDEX_BITS+1:2]     line index
//   [ADDR_WIDTH-1:INDEX_BITS+2] tag
// ---------------------------------------------------------------------------
package cache_pkg;

    localparam int INDEX_BITS = 8;
    localparam int ADDR_WIDTH = 32;
    localparam int DATA_WIDTH = 32;
    localparam int TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int LINES      = 1 << INDEX_BITS;

    typedef logic [INDEX_BITS-1:0] index_t;
    typedef logic [TAG_BITS-1:0]   tag_t;
    typedef logic [DATA_WIDTH-1:0] data_t;
    typedef logic [ADDR_WIDTH-1:0] addr_t;

    // Full view of one cache line. Valid and dirty live in reset flops in
    // the top level; tag and data live in the un-reset line RAM.
    typedef struct packed {
        logic  valid;
        logic  dirty;
        tag_t  tag;
        data_t data;
    } line_t;

    // Line index selected by a byte address.
    function automatic index_t get_index(input addr_t addr);
        return addr[INDEX_BITS+1:2];
    endfunction

    // Tag portion of a byte address.
    function automatic tag_t get_tag(input addr_t addr);
        return addr[ADDR_WIDTH-1:INDEX_BITS+2];
    endfunction

endpackage

// File: rtl/direct_map_cache_if.sv
// ---------------------------------------------------------------------------
// direct_map_cache_if
// Lookup/write bus between a cache controller (master) and the cache
// store (slave).
//   addr         master->slave  byte address for lookup and write
//   write_data   master->slave  word to store
//   write_valid  master->slave  write strobe, sampled on rising clk
//   write_access master->slave  1 = CPU store (dirty), 0 = refill (clean)
//   hit          slave->master  indexed line valid and tag matches
//   data         slave->master  data word of indexed line
//   dirty        slave->master  indexed line valid and dirty (no tag match)
// ---------------------------------------------------------------------------
interface direct_map_cache_if
    import cache_pkg::*;
#(
    parameter int ADDR_W = ADDR_WIDTH,
    parameter int DATA_W = DATA_WIDTH
);

    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] write_data;
    logic              write_valid;
    logic              write_access;
    logic              hit;
    logic [DATA_W-1:0] data;
    logic              dirty;

    modport master (
        output addr,
        output write_data,
        output write_valid,
        output write_access,
        input  hit,
        input  data,
        input  dirty
    );

    modport slave (
        input  addr,
        input  write_data,
        input  write_valid,
        input  write_access,
        output hit,
        output data,
        output dirty
    );

endinterface

// File: rtl/cache_line_ram.sv
// ---------------------------------------------------------------------------
// cache_line_ram
// Plain tag+data storage array: synchronous write, asynchronous read,
// no reset. Line validity is tracked outside this array, so stale
// contents after reset are harmless.
//   clk    write clock
//   we     write enable
//   waddr  write line index
//   wdata  packed {tag, data} to store
//   raddr  read line index
//   rdata  packed {tag, data} at raddr
// ---------------------------------------------------------------------------
module cache_line_ram #(
    parameter int ADDR_BITS = 8,
    parameter int WIDTH     = 54
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [ADDR_BITS-1:0] waddr,
    input  logic [WIDTH-1:0]     wdata,
    input  logic [ADDR_BITS-1:0] raddr,
    output logic [WIDTH-1:0]     rdata
);

    logic [WIDTH-1:0] mem [1 << ADDR_BITS];

    // Store the new line contents on the rising edge when enabled.
    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Read is combinational so the cache lookup has zero-cycle latency.
    assign rdata = mem[raddr];

endmodule

// File: rtl/direct_map_cache.sv
// ---------------------------------------------------------------------------
// direct_map_cache
// Direct-mapped, one-word-per-line cache store with hit and dirty
// detection. Lookup is combinational from bus.addr; fills and stores
// happen on the rising clock edge. No handshake or eviction logic here:
// the enclosing controller decides when to write back and refill.
//   clk      clock, all writes on rising edge
//   reset_n  asynchronous active-low reset, clears every valid/dirty bit
//   bus      direct_map_cache_if.slave lookup/write bus
// ---------------------------------------------------------------------------
module direct_map_cache
    import cache_pkg::*;
#(
    parameter int INDEX_BITS = cache_pkg::INDEX_BITS,
    parameter int ADDR_WIDTH = cache_pkg::ADDR_WIDTH,
    parameter int DATA_WIDTH = cache_pkg::DATA_WIDTH
) (
    input  logic                clk,
    input  logic                reset_n,
    direct_map_cache_if.slave   bus
);

    localparam int NUM_LINES = 1 << INDEX_BITS;
    localparam int TAG_W     = ADDR_WIDTH - INDEX_BITS - 2;
    localparam int RAM_W     = TAG_W + DATA_WIDTH;

    index_t                 lookupIdx;
    tag_t                   lookupTag;
    logic [NUM_LINES-1:0]   valid_q;
    logic [NUM_LINES-1:0]   valid_d;
    logic [NUM_LINES-1:0]   dirty_q;
    logic [NUM_LINES-1:0]   dirty_d;
    logic                   writeEn;
    logic [RAM_W-1:0]       ramWdata;
    logic [RAM_W-1:0]       ramRdata;
    line_t                  lookupLine;
    logic                   unusedOffset;

    assign lookupIdx    = get_index(bus.addr);
    assign lookupTag    = get_tag(bus.addr);
    assign unusedOffset = &{1'b0, bus.addr[1:0]};

    // Gating with reset_n keeps a write strobe held through reset from
    // landing in the array; the valid bits would hide it anyway.
    assign writeEn  = bus.write_valid & reset_n;
    assign ramWdata = {lookupTag, bus.write_data};

    // A write unconditionally claims the indexed line; its dirty state
    // comes solely from whether this is a CPU store or a refill.
    always_comb begin
        valid_d = valid_q;
        dirty_d = dirty_q;
        if (bus.write_valid) begin
            valid_d[lookupIdx] = 1'b1;
            dirty_d[lookupIdx] = bus.write_access;
        end
    end

    // Valid and dirty flags reset asynchronously so hit/dirty drop to 0
    // the moment reset_n falls, without waiting for a clock.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= '0;
            dirty_q <= '0;
        end else begin
            valid_q <= valid_d;
            dirty_q <= dirty_d;
        end
    end

    cache_line_ram #(
        .ADDR_BITS (INDEX_BITS),
        .WIDTH     (RAM_W)
    ) u_line_ram (
        .clk   (clk),
        .we    (writeEn),
        .waddr (lookupIdx),
        .wdata (ramWdata),
        .raddr (lookupIdx),
        .rdata (ramRdata)
    );

    // Assemble the indexed line from flag flops and RAM contents.
    always_comb begin
        lookupLine       = '0;
        lookupLine.valid = valid_q[lookupIdx];
        lookupLine.dirty = dirty_q[lookupIdx];
        lookupLine.tag   = ramRdata[RAM_W-1:DATA_WIDTH];
        lookupLine.data  = ramRdata[DATA_WIDTH-1:0];
    end

    // Dirty ignores the tag so the controller can spot a needed
    // writeback while it is handling a miss.
    assign bus.hit   = lookupLine.valid && (lookupLine.tag == lookupTag);
    assign bus.dirty = lookupLine.valid && lookupLine.dirty;
    assign bus.data  = lookupLine.data;

endmodule

// File: tb/tb_direct_map_cache.sv
// ---------------------------------------------------------------------------
// tb_direct_map_cache
// Self-checking bench for direct_map_cache. A reference model keeps one
// entry per line (valid, dirty, tag, data) computed from plain address
// arithmetic; directed scenarios are followed by randomized traffic.
// ---------------------------------------------------------------------------
module tb_direct_map_cache;

    logic clk;
    logic reset_n;

    int checkCount;
    int errorCount;

    // Reference model, indexed by line number.
    bit          mValid [256];
    bit          mDirty [256];
    int unsigned mTag   [256];
    logic [31:0] mData  [256];

    logic [31:0] writtenAddrs [$];

    direct_map_cache_if bus ();

    direct_map_cache dut (
        .clk     (clk),
        .reset_n (reset_n),
        .bus     (bus)
    );

    // Free-running clock, period 10.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Hard time limit so the bench can never hang.
    initial begin
        #2000000;
        $display("[TB] FAIL timeout: simulation did not finish (got running, need done)");
        $fatal(1, "[TB] timeout");
    end

    function automatic int unsigned lineOf(input logic [31:0] a);
        return (a / 4) % 256;
    endfunction

    function automatic int unsigned tagOf(input logic [31:0] a);
        return a / 1024;
    endfunction

    // Single comparison point: counts and reports.
    task automatic checkOutput(input string name, input logic [31:0] got,
                               input logic [31:0] exp);
        checkCount++;
        if (got !== exp) begin
            errorCount++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, got, exp);
        end
    endtask

    // Set the address and compare hit/dirty/data against the model.
    task automatic checkLookup(input string name, input logic [31:0] a);
        int unsigned l;
        bit expHit;
        bit expDirty;
        bus.addr = a;
        #1;
        l        = lineOf(a);
        expHit   = mValid[l] && (mTag[l] == tagOf(a));
        expDirty = mValid[l] && mDirty[l];
        checkOutput({name, ".hit"},   {31'b0, bus.hit},   {31'b0, expHit});
        checkOutput({name, ".dirty"}, {31'b0, bus.dirty}, {31'b0, expDirty});
        if (expHit) begin
            checkOutput({name, ".data"}, bus.data, mData[l]);
        end
    endtask

    // One write on the next rising edge, then update the model.
    task automatic applyStimulus(input logic [31:0] a, input logic [31:0] d,
                                 input bit acc);
        int unsigned l;
        @(negedge clk);
        bus.addr         = a;
        bus.write_data   = d;
        bus.write_access = acc;
        bus.write_valid  = 1'b1;
        @(posedge clk);
        #1;
        bus.write_valid = 1'b0;
        l         = lineOf(a);
        mValid[l] = 1'b1;
        mDirty[l] = acc;
        mTag[l]   = tagOf(a);
        mData[l]  = d;
        writtenAddrs.push_back(a);
    endtask

    task automatic clearModel();
        for (int i = 0; i < 256; i++) begin
            mValid[i] = 1'b0;
            mDirty[i] = 1'b0;
        end
        writtenAddrs.delete();
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] d;
        checkCount = 0;
        errorCount = 0;
        bus.addr         = '0;
        bus.write_data   = '0;
        bus.write_valid  = 1'b0;
        bus.write_access = 1'b0;
        clearModel();

        // Reset then lookup.
        reset_n = 1'b0;
        repeat (3) @(posedge clk);
        #2 reset_n = 1'b1;
        checkLookup("reset_a0", 32'h0000_0000);
        checkLookup("reset_a404", 32'h0000_0404);

        // Refill and hit, including a different byte offset.
        applyStimulus(32'h0000_1004, 32'hDEAD_BEEF, 1'b0);
        checkLookup("refill", 32'h0000_1004);
        checkOutput("refill.hitConst", {31'b0, bus.hit}, 32'd1);
        checkLookup("refill_off", 32'h0000_1006);

        // Conflict miss and eviction.
        checkLookup("conflict", 32'h0000_2004);
        checkOutput("conflict.missConst", {31'b0, bus.hit}, 32'd0);
        applyStimulus(32'h0000_2004, 32'h1234_5678, 1'b0);
        checkLookup("conflict_fill", 32'h0000_2004);
        checkLookup("evicted", 32'h0000_1004);

        // Dirty tracking.
        applyStimulus(32'h0000_0010, 32'hA5A5_A5A5, 1'b1);
        checkLookup("store", 32'h0000_0010);
        checkOutput("store.dirtyConst", {31'b0, bus.dirty}, 32'd1);
        checkLookup("store_alias", 32'h0000_0410);
        applyStimulus(32'h0000_0410, 32'h0BAD_F00D, 1'b0);
        checkLookup("clean_refill", 32'h0000_0410);
        checkOutput("clean.dirtyConst", {31'b0, bus.dirty}, 32'd0);

        // Same-edge read/write: no combinational bypass.
        @(negedge clk);
        bus.addr         = 32'h0000_0020;
        bus.write_data   = 32'hCAFE_0020;
        bus.write_access = 1'b0;
        bus.write_valid  = 1'b1;
        #1;
        checkOutput("bypass.before", {31'b0, bus.hit}, 32'd0);
        @(posedge clk);
        #1;
        bus.write_valid = 1'b0;
        mValid[8] = 1'b1;
        mDirty[8] = 1'b0;
        mTag[8]   = 0;
        mData[8]  = 32'hCAFE_0020;
        writtenAddrs.push_back(32'h0000_0020);
        checkOutput("bypass.after", {31'b0, bus.hit}, 32'd1);
        checkLookup("bypass_after", 32'h0000_0020);

        // Async reset between edges with a write held active.
        applyStimulus(32'h0000_3010, 32'h1111_2222, 1'b1);
        @(negedge clk);
        #2;
        bus.addr         = 32'h0000_3010;
        bus.write_data   = 32'h7777_8888;
        bus.write_access = 1'b1;
        bus.write_valid  = 1'b1;
        #1;
        checkOutput("prereset.hit", {31'b0, bus.hit}, 32'd1);
        reset_n = 1'b0;
        #1;
        checkOutput("async.hit",   {31'b0, bus.hit},   32'd0);
        checkOutput("async.dirty", {31'b0, bus.dirty}, 32'd0);
        bus.addr = 32'h0000_0040;
        @(posedge clk);
        #1;
        bus.write_valid = 1'b0;
        reset_n = 1'b1;
        begin
            logic [31:0] prev [$];
            prev = writtenAddrs;
            clearModel();
            foreach (prev[i]) checkLookup("after_reset", prev[i]);
        end
        checkLookup("suppressed", 32'h0000_0040);

        // Randomized traffic over a small tag/index space to force reuse.
        for (int i = 0; i < 400; i++) begin
            a = ($urandom_range(0, 3) << 10) | ($urandom_range(0, 15) << 2)
                | $urandom_range(0, 3);
            d = $urandom;
            if ($urandom_range(0, 9) < 4) begin
                applyStimulus(a, d, 1'($urandom_range(0, 1)));
            end
            checkLookup("random", a);
        end

        $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
        $finish;
    end

endmodule

// File: doc/direct_map_cache.md
Name: direct_map_cache

Overview:
- Single-word-per-line, direct-mapped cache storage array with hit detection.
- Used as the tag/data store inside the instruction cache; also usable as a data-cache store via the dirty tracking.
- Lookup is combinational from `addr`. Line fills and writes happen on the clock edge.
- Holds no handshake logic: the enclosing cache controller owns the miss FSM and the AXI traffic.

Parameters:
- INDEX_BITS, 8, log2 of line count (256 lines).
- ADDR_WIDTH, 32, byte-address width.
- DATA_WIDTH, 32, line/word width. Fixed at 32; byte offset is addr[1:0].

Ports:
- clk  input  1  Clock. All writes occur on its rising edge. The parent passes an inverted clock when it needs negedge operation.
- reset_n  input  1  Asynchronous, active-low reset.
- addr  input  32  Byte address for lookup and write. addr[1:0] ignored.
- hit  output  1  Combinational: the indexed line is valid and its tag equals the addr tag.
- data  output  32  Combinational: data word of the indexed line. Undefined meaning when hit=0.
- write_data  input  32  Word to store.
- write_valid  input  1  Write strobe. Sampled on rising clk.
- write_access  input  1  1 = CPU store (line becomes dirty); 0 = refill from memory (line becomes clean).
- dirty  output  1  Combinational: the indexed line is valid and its dirty bit is set. Tag match is not required, so the controller can detect writeback need on a miss.

Behaviour:
- Address split:
  - offset = addr[1:0], ignored.
  - index = addr[INDEX_BITS+1:2].
  - tag = addr[31:INDEX_BITS+2] (22 bits at default).
- Per-line storage: valid bit, dirty bit, tag, data word.
- Reset: reset_n low asynchronously clears every valid and dirty bit.
  - hit=0 and dirty=0 immediately, for any addr.
  - Tag and data arrays are not reset; data output may carry stale or X values.
- Reset mid-write: reset wins. A write_valid on the same edge while reset_n is low is discarded.
- Lookup: hit, data and dirty are pure functions of addr and current array contents. Zero-cycle latency.
- Write on rising clk, when reset_n is high and write_valid=1:
  - Line[index] is loaded with tag=addr tag, data=write_data, valid=1, dirty=write_access.
  - Any previous occupant of the line is overwritten unconditionally. Eviction/writeback is the controller's job and must happen before the write.
- Write visibility: new contents appear on hit/data/dirty after the edge, not combinationally. There is no write-through bypass.
- Write to a hitting line with write_access=0 clears dirty. Write with write_access=1 sets it.
- write_valid=0: arrays hold their contents.
- Aliasing: two addresses with the same index but different tags evict each other. After writing A, looking up B (same index) gives hit=0, and dirty reflects A's line.
- No FSM inside this block. No X on hit or dirty after reset.

Decomposition:
- Package cache_pkg holds:
  - INDEX_BITS and the derived TAG_BITS.
  - A line struct typedef {valid, dirty, tag, data}.
  - Helper functions get_index(addr) and get_tag(addr).
- Sub-module cache_line_ram holds the tag+data array. It is a plain array, not reset, with synchronous write and asynchronous read.
- The valid and dirty bit vectors stay in the top level as flops with async reset.

Test Plan:
- Reset then lookup:
  - Stimulus: assert reset_n=0, release, set addr=0x0000_0000 and addr=0x0000_0404.
  - Response: hit=0, dirty=0 for both.
- Refill and hit:
  - Stimulus: addr=0x0000_1004, write_data=0xDEAD_BEEF, write_valid=1, write_access=0 for one edge, then deassert.
  - Response: hit=1, data=0xDEAD_BEEF, dirty=0.
  - Also: addr=0x0000_1006 (same word, different offset) also hits.
- Conflict miss:
  - Stimulus: after the refill above, addr=0x0000_2004 (same index 1, different tag).
  - Response: hit=0.
  - Then refill 0x0000_2004 with 0x1234_5678: hit=1, data=0x1234_5678. Back to addr=0x0000_1004: hit=0.
- Dirty tracking:
  - Stimulus: write addr=0x0000_0010, data=0xA5A5_A5A5, write_access=1.
  - Response: hit=1, dirty=1.
  - Then addr=0x0000_0410 (same index, other tag): hit=0, dirty=1.
  - Then refill 0x0000_0410 with write_access=0: dirty=0.
- Async reset mid-operation:
  - Stimulus: with several valid lines, pulse reset_n low between clock edges; hold write_valid=1 during reset.
  - Response: hit drops to 0 immediately, without waiting for a clock. No line becomes valid from the suppressed write; all prior lines miss after release.
- Same-edge read/write:
  - Stimulus: addr=0x0000_0020 missing, write_valid=1.
  - Response: before the edge hit=0; after the edge hit=1 with the new data. No combinational bypass.
